adc_serial_emu_x16: RTL and testbench

ADC_SERIAL_EMU_X16 -- requirements
Module: adc_serial_emu_x16

---
 rtl/adc_serial_emu_x16_pkg.sv | 17 +
 rtl/adc_serial_emu_x16_if.sv | 29 ++
 rtl/adc_serial_emu_x16_sync_edge.sv | 33 +++
 rtl/adc_serial_emu_x16.sv | 137 +++++++++++++
 tb/tb_adc_serial_emu_x16.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/adc_serial_emu_x16_pkg.sv
// Shared constants and state encoding for the serial ADC emulator.
// Holds the data width, the default conversion length and ramp step,
// and the four-state converter state enum.
package adc_serial_emu_x16_pkg;

  localparam int DATA_W = 16;
  localparam int unsigned CONV_CYCLES_DEF = 40;
  localparam logic [DATA_W-1:0] RAMP_STEP_DEF = 16'h0101;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CONVERT = 2'd1,
    ST_READY   = 2'd2,
    ST_SHIFT   = 2'd3
  } state_e;

endpackage

// File: rtl/adc_serial_emu_x16_if.sv
// Pin-level bus between an ADC master and the serial ADC emulator.
// master: drives adc_reset_i, pd_i, cnvst_n_i, cs_n_i, rd_n_i, sclk_i, sample_i;
//         receives busy_o, sdout_o, sample_taken_o, overrun_o. slave: the reverse.
interface adc_serial_emu_x16_if;
  import adc_serial_emu_x16_pkg::*;

  logic              adc_reset_i;
  logic              pd_i;
  logic              cnvst_n_i;
  logic              cs_n_i;
  logic              rd_n_i;
  logic              sclk_i;
  logic [DATA_W-1:0] sample_i;
  logic              busy_o;
  logic              sdout_o;
  logic              sample_taken_o;
  logic              overrun_o;

  modport master (
    output adc_reset_i, pd_i, cnvst_n_i, cs_n_i, rd_n_i, sclk_i, sample_i,
    input  busy_o, sdout_o, sample_taken_o, overrun_o
  );

  modport slave (
    input  adc_reset_i, pd_i, cnvst_n_i, cs_n_i, rd_n_i, sclk_i, sample_i,
    output busy_o, sdout_o, sample_taken_o, overrun_o
  );

endinterface

// File: rtl/adc_serial_emu_x16_sync_edge.sv
// Two-flop synchronizer with registered rise/fall pulses (the sync_edge block).
// Latency: q follows d after 2 clk; rise/fall pulse in the same cycle q changes.
// Ports: clk, rst (sync, active-high), d (async in), q, rise, fall. No backpressure.
module adc_serial_emu_x16_sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);

  logic meta;

  // Pulses compare the value about to enter q with q itself, so each edge
  // pulse lines up with the cycle in which the synchronized level changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      rise <= meta & ~q;
      fall <= ~meta & q;
    end
  end

endmodule

// File: rtl/adc_serial_emu_x16.sv
// Serial ADC emulator: cnvst starts a conversion, busy for CONV_CYCLES, then a
// 16-bit word is shifted out MSB first on sclk while cs_n and rd_n are low.
// Latency: 3 clk from any async pin to action. Ports: clk, rst, bus (slave).
module adc_serial_emu_x16
  import adc_serial_emu_x16_pkg::*;
#(
  parameter int unsigned       CONV_CYCLES  = CONV_CYCLES_DEF,
  parameter int unsigned       PATTERN_MODE = 0,
  parameter logic [DATA_W-1:0] RAMP_STEP    = RAMP_STEP_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  adc_serial_emu_x16_if.slave  bus
);

  localparam logic [1:0] IDLE    = ST_IDLE;
  localparam logic [1:0] CONVERT = ST_CONVERT;
  localparam logic [1:0] READY   = ST_READY;
  localparam logic [1:0] SHIFT   = ST_SHIFT;

  localparam logic [15:0] CNT_INIT = 16'(CONV_CYCLES - 1);

  // Synchronized levels and edge pulses
  logic cnvst_q, cnvst_rise, cnvst_fall;
  logic cs_q, cs_rise, cs_fall;
  logic rd_q, rd_rise, rd_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic adc_reset_q, adc_reset_rise, adc_reset_fall;
  logic pd_q, pd_rise, pd_fall;

  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b1)) u_sync_cnvst (
    .clk(clk), .rst(rst), .d(bus.cnvst_n_i), .q(cnvst_q), .rise(cnvst_rise), .fall(cnvst_fall));
  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(clk), .rst(rst), .d(bus.cs_n_i), .q(cs_q), .rise(cs_rise), .fall(cs_fall));
  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b1)) u_sync_rd (
    .clk(clk), .rst(rst), .d(bus.rd_n_i), .q(rd_q), .rise(rd_rise), .fall(rd_fall));
  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst(rst), .d(bus.sclk_i), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall));
  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b0)) u_sync_adc_reset (
    .clk(clk), .rst(rst), .d(bus.adc_reset_i), .q(adc_reset_q), .rise(adc_reset_rise),
    .fall(adc_reset_fall));
  adc_serial_emu_x16_sync_edge #(.RST_VAL(1'b0)) u_sync_pd (
    .clk(clk), .rst(rst), .d(bus.pd_i), .q(pd_q), .rise(pd_rise), .fall(pd_fall));

  // Only some edges/levels drive the converter; the rest are deliberately dropped.
  logic unused_ok;
  assign unused_ok = ^{cnvst_q, cnvst_rise, cs_fall, rd_fall, sclk_q, sclk_fall,
                       adc_reset_rise, adc_reset_fall, pd_rise, pd_fall};

  logic [1:0]        state;
  logic              busy;
  logic              sample_taken;
  logic              overrun;
  logic [15:0]       cnt;
  logic [3:0]        bit_cnt;
  logic [DATA_W-1:0] latched;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] ramp;
  logic [DATA_W-1:0] src;
  logic              sel;
  logic              abort;

  assign src   = (PATTERN_MODE == 1) ? ramp : bus.sample_i;
  assign sel   = ~cs_q & ~rd_q;
  assign abort = cs_rise | rd_rise;

  always_ff @(posedge clk) begin
    sample_taken <= 1'b0;
    overrun      <= 1'b0;
    if (rst) begin
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      latched <= '0;
      shreg   <= '0;
      ramp    <= '0;
    end else if (adc_reset_q) begin
      // Converter reset: same as rst but the ramp keeps counting across it,
      // and any cnvst edge seen meanwhile is dropped silently.
      state   <= IDLE;
      busy    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      latched <= '0;
      shreg   <= '0;
    end else begin
      // Any start request outside IDLE is rejected, including the cycle an
      // abort or the final bit returns the state to IDLE.
      if (cnvst_fall && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (cnvst_fall && !pd_q) begin
            latched      <= src;
            ramp         <= ramp + RAMP_STEP;
            sample_taken <= 1'b1;
            busy         <= 1'b1;
            cnt          <= CNT_INIT;
            state        <= CONVERT;
          end
        end
        CONVERT: begin
          if (cnt == 16'd0) begin
            busy    <= 1'b0;
            shreg   <= latched;
            bit_cnt <= '0;
            state   <= READY;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        READY, SHIFT: begin
          if (abort) begin
            shreg <= '0;
            state <= IDLE;
          end else if (sclk_rise && sel) begin
            bit_cnt <= bit_cnt + 4'd1;
            if (bit_cnt == 4'd15) begin
              shreg <= '0;
              state <= IDLE;
            end else begin
              shreg <= {shreg[DATA_W-2:0], 1'b0};
              state <= SHIFT;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy_o         = busy;
  assign bus.sample_taken_o = sample_taken;
  assign bus.overrun_o      = overrun;
  assign bus.sdout_o        = ((state == READY) || (state == SHIFT)) & sel & shreg[DATA_W-1];

endmodule

// File: tb/tb_adc_serial_emu_x16.sv
// Bench for adc_serial_emu_x16: one sample-source and one ramp instance share stimulus.
// Expected words are queued on each accepted start; a serial monitor pops and compares.
// Pulse counts and busy durations are checked against a bench-side model.
module tb_adc_serial_emu_x16;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        adc_reset = 1'b0, pd = 1'b0, cnvst_n = 1'b1, cs_n = 1'b1, rd_n = 1'b1, sclk = 1'b0;
  logic [15:0] sample = 16'h0;

  adc_serial_emu_x16_if if0 ();
  adc_serial_emu_x16_if if1 ();

  assign if0.adc_reset_i = adc_reset; assign if1.adc_reset_i = adc_reset;
  assign if0.pd_i        = pd;        assign if1.pd_i        = pd;
  assign if0.cnvst_n_i   = cnvst_n;   assign if1.cnvst_n_i   = cnvst_n;
  assign if0.cs_n_i      = cs_n;      assign if1.cs_n_i      = cs_n;
  assign if0.rd_n_i      = rd_n;      assign if1.rd_n_i      = rd_n;
  assign if0.sclk_i      = sclk;      assign if1.sclk_i      = sclk;
  assign if0.sample_i    = sample;    assign if1.sample_i    = sample;

  adc_serial_emu_x16 #(.PATTERN_MODE(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));
  adc_serial_emu_x16 #(.PATTERN_MODE(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));

  int checks = 0, errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reference model state
  logic [15:0] q0[$], q1[$];
  logic [15:0] m_ramp = 16'h0000;
  bit          m_idle = 1'b1;
  int          exp_st = 0, exp_ov = 0;

  // Pulse counters and busy-run lengths observed on the DUTs
  int st0 = 0, st1 = 0, ov0 = 0, ov1 = 0;
  int cur0 = 0, cur1 = 0, last0 = 0, last1 = 0;

  always @(negedge clk) begin
    if (if0.sample_taken_o) st0++;
    if (if1.sample_taken_o) st1++;
    if (if0.overrun_o) ov0++;
    if (if1.overrun_o) ov1++;
    if (if0.busy_o) cur0++; else if (cur0 != 0) begin last0 = cur0; cur0 = 0; end
    if (if1.busy_o) cur1++; else if (cur1 != 0) begin last1 = cur1; cur1 = 0; end
  end

  // Serial receiver: a bit is taken at each sclk rise while selected; a word
  // ends after 16 bits or early when cs_n rises (partial words compare MSBs).
  int          nb  = 0;
  logic [15:0] rx0 = 16'h0, rx1 = 16'h0;

  task automatic word_done(input int n);
    logic [15:0] e, mask;
    mask = 16'((32'd1 << n) - 1);
    if (q0.size() == 0) begin
      checks++; errors++; $display("FAIL word0: got a word, expected none queued");
    end else begin
      e = q0.pop_front();
      check("word0", 32'(rx0 & mask), 32'((e >> (16 - n)) & mask));
    end
    if (q1.size() == 0) begin
      checks++; errors++; $display("FAIL word1: got a word, expected none queued");
    end else begin
      e = q1.pop_front();
      check("word1", 32'(rx1 & mask), 32'((e >> (16 - n)) & mask));
    end
  endtask

  always @(posedge sclk) begin
    if (!cs_n && !rd_n) begin
      rx0 = {rx0[14:0], if0.sdout_o};
      rx1 = {rx1[14:0], if1.sdout_o};
      nb++;
      if (nb == 16) begin
        word_done(16);
        nb = 0;
      end
    end
  end

  always @(posedge cs_n) begin
    if (nb != 0) begin
      word_done(nb);
      nb = 0;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_conv(input logic [15:0] s);
    sample = s;
    if (m_idle && !pd) begin
      q0.push_back(s);
      q1.push_back(m_ramp);
      m_ramp = m_ramp + 16'h0101;
      exp_st++;
      m_idle = 1'b0;
    end else if (!m_idle) begin
      exp_ov++;
    end
    cnvst_n = 1'b0; cyc(2); cnvst_n = 1'b1; cyc(2);
  endtask

  task automatic wait_busy_low();
    for (int i = 0; i < 200 && (if0.busy_o || if1.busy_o); i++) cyc(1);
    check("busy_timeout", {if0.busy_o, if1.busy_o}, 0);
    cyc(1);
    check("busy_len0", last0, 40);
    check("busy_len1", last1, 40);
  endtask

  // Clocks out n bits then raises cs_n (an abort when n < 16).
  task automatic do_read(input int n);
    cs_n = 1'b0; rd_n = 1'b0; cyc(4);
    for (int i = 0; i < n; i++) begin
      sclk = 1'b1; cyc(3); sclk = 1'b0; cyc(3);
    end
    if (n == 16) check("sdout_after_16", {if0.sdout_o, if1.sdout_o}, 0);
    cs_n = 1'b1; cyc(3);
    check("sdout_cs_high", {if0.sdout_o, if1.sdout_o}, 0);
    rd_n = 1'b1; cyc(2);
    m_idle = 1'b1;
  endtask

  initial begin
    repeat (5) @(posedge clk);
    #2;
    check("rst_busy", {if0.busy_o, if1.busy_o}, 0);
    check("rst_sdout", {if0.sdout_o, if1.sdout_o}, 0);
    check("rst_pulses", st0 + st1 + ov0 + ov1, 0);
    rst = 1'b0; cyc(5);

    // Basic conversion, then two more so the ramp shows 0000/0101/0202
    do_conv(16'hA5C3); wait_busy_low(); do_read(16);
    check("st_once", st0, 1);
    for (int k = 0; k < 2; k++) begin
      do_conv(16'($urandom)); wait_busy_low(); do_read(16);
    end

    // Second start while busy: overrun, duration and data unaffected
    do_conv(16'h1234); cyc(10); do_conv(16'hBEEF);
    wait_busy_low(); do_read(16);
    check("ov_busy0", ov0, exp_ov); check("ov_busy1", ov1, exp_ov);

    // Start request while the word is waiting to be read
    do_conv(16'($urandom)); wait_busy_low(); do_conv(16'($urandom)); do_read(16);

    // Abort after 5 bits, then a full word
    do_conv(16'($urandom)); wait_busy_low(); do_read(5);
    do_conv(16'($urandom)); wait_busy_low(); do_read(16);

    // Abort coincident with a start request: the start becomes an overrun
    do_conv(16'($urandom)); wait_busy_low();
    cs_n = 1'b0; rd_n = 1'b0; cyc(4);
    for (int i = 0; i < 7; i++) begin
      sclk = 1'b1; cyc(3); sclk = 1'b0; cyc(3);
    end
    cs_n = 1'b1; cnvst_n = 1'b0; exp_ov++; cyc(2); cnvst_n = 1'b1; rd_n = 1'b1;
    m_idle = 1'b1; cyc(6);
    check("abort_start_busy", {if0.busy_o, if1.busy_o}, 0);
    check("abort_start_st", st0, exp_st);

    // Converter reset mid-conversion
    do_conv(16'($urandom)); cyc(12);
    adc_reset = 1'b1; cyc(3);
    check("adc_reset_busy", {if0.busy_o, if1.busy_o}, 0);
    adc_reset = 1'b0; cyc(5);
    void'(q0.pop_back()); void'(q1.pop_back()); m_idle = 1'b1;
    check("adc_reset_ov", ov0, exp_ov);
    do_conv(16'($urandom)); wait_busy_low(); do_read(16);

    // Power-down blocks new conversions
    pd = 1'b1; cyc(4);
    do_conv(16'($urandom)); cyc(10);
    check("pd_busy", {if0.busy_o, if1.busy_o}, 0);
    check("pd_st", st0, exp_st); check("pd_ov", ov0, exp_ov);
    pd = 1'b0; cyc(4);

    // Random conversions
    for (int k = 0; k < 4; k++) begin
      do_conv(16'($urandom)); wait_busy_low(); do_read(16);
      cyc(int'($urandom_range(0, 5)));
    end

    cyc(5);
    check("st_total0", st0, exp_st); check("st_total1", st1, exp_st);
    check("ov_total0", ov0, exp_ov); check("ov_total1", ov1, exp_ov);
    check("queue_left", q0.size() + q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
